// File: rtl/upscaler_pkg.sv
// Shared types and constants for the upscaler front end: window lane layout,
// window-generator control states and the window pipeline latency.
package upscaler_pkg;

  localparam int DW_DEFAULT  = 8;
  localparam int WIN_LATENCY = 2;

  // Lane positions inside the packed 2x2 window word (lane 0 = LSBs)
  localparam int P00_IDX = 3;
  localparam int P10_IDX = 2;
  localparam int P01_IDX = 1;
  localparam int P11_IDX = 0;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FIRST_LINE = 2'd1,
    BODY       = 2'd2
  } win_state_t;

endpackage

// File: rtl/line_ram_rbw.sv
// Single-port line memory, read-before-write, registered read data.
// Array contents are not reset; only the read register is.
module line_ram_rbw #(
  parameter int DW        = 8,
  parameter int AW        = 11,
  parameter int MAX_WIDTH = 1280
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Old contents are returned even when the same address is written this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (en) rdata <= mem[addr];
  end

endmodule

// File: rtl/bilinear_win2x2_gen.sv
// Raster pixel stream to packed 2x2 bilinear window {p00,p10,p01,p11}, 2-cycle latency.
// Optional macro BORDER_ZERO_EN: border pixels forced to 0 instead of replicated.
module bilinear_win2x2_gen
  import upscaler_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_WIDTH = 1280,
  parameter int AW        = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync_in,
  input  logic          hsync_in,
  input  logic [DW-1:0] pix_in,
  output logic          vsync_o,
  output logic          hsync_o,
  output logic [4*DW-1:0] win_o,
  output logic          ovf_o
);

  // One extra bit so the counter can hold MAX_WIDTH itself when 2^AW == MAX_WIDTH
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_WIDTH);

  function automatic logic [CW-1:0] col_inc_sat(input logic [CW-1:0] c);
    return (c >= COL_MAX) ? COL_MAX : c + 1'b1;
  endfunction

  function automatic logic [DW-1:0] border_pix(input logic [DW-1:0] p);
`ifdef BORDER_ZERO_EN
    return p & {DW{1'b0}};
`else
    return p;
`endif
  endfunction

  win_state_t    state, state_nxt;
  logic          vsync_q, hsync_q;
  logic [CW-1:0] col_cnt;
  logic          vrise, ovf_pix, first_col, top_bd, ram_en;
  logic [DW-1:0] ram_rdata;

  logic          vld_p1, vs_p1, first_col_p1, top_bd_p1, ovf_st_p1;
  logic [DW-1:0] cur_p1;
  logic [DW-1:0] cur_p2, top_p2;
  logic [DW-1:0] top_eff, p00, p10, p01, p11;
  logic [4*DW-1:0] win_nxt;

  assign vrise     = vsync_in & ~vsync_q;
  assign ovf_pix   = hsync_in && (col_cnt >= COL_MAX);
  assign first_col = (col_cnt == '0);
  assign top_bd    = (state != BODY) || ovf_pix;
  assign ram_en    = hsync_in && !ovf_pix;

  always_comb begin
    state_nxt = state;
    if (!vsync_in)                                        state_nxt = WAIT_FRAME;
    else if (vrise)                                       state_nxt = FIRST_LINE;
    else if (state == FIRST_LINE && hsync_q && !hsync_in) state_nxt = BODY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_FRAME;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      col_cnt <= '0;
    end else begin
      state   <= state_nxt;
      vsync_q <= vsync_in;
      hsync_q <= hsync_in;
      col_cnt <= hsync_in ? col_inc_sat(col_cnt) : '0;
    end
  end

  line_ram_rbw #(
    .DW        (DW),
    .AW        (AW),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_line_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ram_en),
    .we    (ram_en),
    .addr  (col_cnt[AW-1:0]),
    .wdata (pix_in),
    .rdata (ram_rdata)
  );

  // Stage p1: current pixel, border flags and sticky overflow (RAM read lands here too)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      vs_p1        <= 1'b0;
      first_col_p1 <= 1'b0;
      top_bd_p1    <= 1'b0;
      ovf_st_p1    <= 1'b0;
      cur_p1       <= '0;
    end else begin
      vld_p1       <= hsync_in;
      vs_p1        <= vsync_in;
      first_col_p1 <= first_col;
      top_bd_p1    <= top_bd;
      ovf_st_p1    <= (vrise ? 1'b0 : ovf_st_p1) | ovf_pix;
      if (hsync_in) cur_p1 <= pix_in;
    end
  end

  // top_p2 keeps the already border-resolved top pixel, so p00 inherits the same rule
  always_comb begin
    top_eff = top_bd_p1 ? border_pix(cur_p1) : ram_rdata;
    p11     = cur_p1;
    p10     = top_eff;
    p01     = first_col_p1 ? border_pix(cur_p1)  : cur_p2;
    p00     = first_col_p1 ? border_pix(top_eff) : top_p2;
    win_nxt = '0;
    win_nxt[P00_IDX*DW +: DW] = p00;
    win_nxt[P10_IDX*DW +: DW] = p10;
    win_nxt[P01_IDX*DW +: DW] = p01;
    win_nxt[P11_IDX*DW +: DW] = p11;
  end

  // Stage p2: registered window and delayed framing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      ovf_o   <= 1'b0;
      win_o   <= '0;
      cur_p2  <= '0;
      top_p2  <= '0;
    end else begin
      hsync_o <= vld_p1;
      vsync_o <= vs_p1;
      ovf_o   <= ovf_st_p1;
      if (vld_p1) begin
        win_o  <= win_nxt;
        cur_p2 <= cur_p1;
        top_p2 <= top_eff;
      end
    end
  end

endmodule
